// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel stream mux, fixed-select or round-robin
// arbitration, packet locking and a registered output beat.
module stream_mux_rr #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [CHANNELS*WIDTH-1:0] i_in_data,
  input  logic [CHANNELS-1:0]       i_in_valid,
  input  logic [CHANNELS-1:0]       i_in_last,
  output logic [CHANNELS-1:0]       o_in_ready,
  input  logic                      i_mode,
  input  logic [SEL_W-1:0]          i_sel,
  output logic [WIDTH-1:0]          o_out_data,
  output logic                      o_out_valid,
  output logic                      o_out_last,
  output logic [SEL_W-1:0]          o_out_ch,
  input  logic                      i_out_ready
);

  typedef enum logic {ARB, LOCK} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_lock_ch;
  logic [SEL_W-1:0] w_lock_ch_nxt;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_ptr_nxt;

  logic             w_gnt_vld;
  logic [SEL_W-1:0] w_gnt_ch;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_gnt_last;
  logic             w_free;
  logic             w_load;
  int               w_idx;

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic [SEL_W-1:0] r_out_ch;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_ch  = '0;
    w_idx     = 0;
    if (r_state == LOCK) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (r_lock_ch == SEL_W'(i) && i_in_valid[i]) begin
          w_gnt_vld = 1'b1;
          w_gnt_ch  = r_lock_ch;
        end
      end
    end else if (!i_mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (i_sel == SEL_W'(i) && i_in_valid[i]) begin
          w_gnt_vld = 1'b1;
          w_gnt_ch  = i_sel;
        end
      end
    end else begin
      // Walk from the farthest slot to the nearest so ptr+1 wins last.
      for (int k = CHANNELS; k >= 1; k--) begin
        w_idx = int'(r_ptr) + k;
        if (w_idx >= CHANNELS) w_idx = w_idx - CHANNELS;
        for (int i = 0; i < CHANNELS; i++) begin
          if (i == w_idx && i_in_valid[i]) begin
            w_gnt_vld = 1'b1;
            w_gnt_ch  = SEL_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    w_gnt_last = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_gnt_ch == SEL_W'(i)) begin
        w_gnt_data = i_in_data[i*WIDTH +: WIDTH];
        w_gnt_last = i_in_last[i];
      end
    end
  end

  assign w_free = !r_out_valid || i_out_ready;
  assign w_load = i_rst_n && w_gnt_vld && w_free;

  always_comb begin
    o_in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_load && w_gnt_ch == SEL_W'(i)) o_in_ready[i] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lock_ch_nxt = r_lock_ch;
    w_ptr_nxt     = r_ptr;
    case (r_state)
      ARB: begin
        if (w_load) begin
          w_ptr_nxt = w_gnt_ch;
          if (!w_gnt_last) begin
            w_state_nxt   = LOCK;
            w_lock_ch_nxt = w_gnt_ch;
          end
        end
      end
      LOCK: begin
        if (w_load && w_gnt_last) w_state_nxt = ARB;
      end
      default: w_state_nxt = ARB;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ARB;
      r_lock_ch <= '0;
      r_ptr     <= SEL_W'(CHANNELS - 1);
    end else begin
      r_state   <= w_state_nxt;
      r_lock_ch <= w_lock_ch_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_ch    <= '0;
    end else if (w_load) begin
      r_out_data  <= w_gnt_data;
      r_out_valid <= 1'b1;
      r_out_last  <= w_gnt_last;
      r_out_ch    <= w_gnt_ch;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_last  = r_out_last;
  assign o_out_ch    = r_out_ch;

endmodule
